// File: rtl/cic_decimator_1bit.sv
// cic_decimator_1bit: 3rd-order decimating CIC filter for a 1-bit sigma-delta stream, with a valid/ready PCM output.
// Define CIC_ROUND_EN to round half up before the right shift instead of truncating.
module cic_decimator_1bit #(
   parameter int MAX_RATE_LOG2 = 8,
   parameter int OUT_WIDTH = 16
) (
   input  logic                 filter_clock,
   input  logic                 reset,
   input  logic                 bitIn,
   input  logic [3:0]           rateLog2,
   output logic [OUT_WIDTH-1:0] sample_out,
   output logic                 sample_valid,
   input  logic                 sample_ready,
   output logic                 overrun,
   input  logic                 clear_overrun
);
   localparam int ACC_WIDTH = 3*MAX_RATE_LOG2+2;
   localparam int WW = ACC_WIDTH+OUT_WIDTH;
   localparam logic [5:0] OW1 = 6'(OUT_WIDTH-1);
   localparam logic [3:0] KMAX = 4'(MAX_RATE_LOG2);
   localparam logic signed [WW-1:0] SAT_HI = WW'(2**(OUT_WIDTH-1)-1);
   localparam logic signed [WW-1:0] SAT_LO = ~SAT_HI;
   logic [3:0] k_in, keff;
   logic [MAX_RATE_LOG2-1:0] cnt;
   logic [MAX_RATE_LOG2:0] rmax;
   logic signed [ACC_WIDTH-1:0] x, i1, i2, i3, i1n, i2n, i3n, d1, d2, d3, c1, c2, c3;
   logic signed [WW-1:0] ext, rnd, sum, wide;
   logic [OUT_WIDTH-1:0] sat;
   logic [5:0] tk, rsh, lsh;
   logic [1:0] settle;
   logic strobe, restart, load, set_ovr;
   // rate clamp, integrator/comb chain, scaling and saturation
   always_comb begin
      k_in = rateLog2 == 4'd0 ? 4'd1 : rateLog2 > KMAX ? KMAX : rateLog2;
      restart = k_in != keff;
      rmax = (MAX_RATE_LOG2+1)'((1 << keff) - 1);
      strobe = {1'b0, cnt} == rmax;
      x = bitIn ? ACC_WIDTH'(1) : '1;
      i1n = i1 + x;
      i2n = i2 + i1n;
      i3n = i3 + i2n;
      c1 = i3n - d1;
      c2 = c1 - d2;
      c3 = c2 - d3;
      tk = 6'(keff) * 6'd3;
      rsh = tk - OW1;
      lsh = OW1 - tk;
      ext = WW'(c3);
`ifdef CIC_ROUND_EN
      rnd = tk > OW1 ? WW'(1) << (rsh - 6'd1) : '0;
`else
      rnd = '0;
`endif
      sum = ext + rnd;
      wide = tk > OW1 ? sum >>> rsh : ext <<< lsh;
      sat = wide > SAT_HI ? SAT_HI[OUT_WIDTH-1:0] : wide < SAT_LO ? SAT_LO[OUT_WIDTH-1:0] : wide[OUT_WIDTH-1:0];
      load = strobe && !restart && settle == 2'd0;
      set_ovr = load && sample_valid && !sample_ready;
   end
   // filter state: restart on reset or rate change, otherwise integrate every cycle and comb on strobe
   always_ff @(posedge filter_clock) begin
      if (reset || restart) begin
         keff <= k_in;
         cnt <= '0;
         i1 <= '0;
         i2 <= '0;
         i3 <= '0;
         d1 <= '0;
         d2 <= '0;
         d3 <= '0;
         settle <= 2'd3;
      end else begin
         i1 <= i1n;
         i2 <= i2n;
         i3 <= i3n;
         cnt <= strobe ? '0 : cnt + 1'b1;
         if (strobe) begin
            d1 <= i3n;
            d2 <= c1;
            d3 <= c2;
            if (settle != 2'd0) settle <= settle - 2'd1;
         end
      end
   end
   // output sample register, valid/ready handshake and sticky overrun
   always_ff @(posedge filter_clock) begin
      if (reset) begin
         sample_out <= '0;
         sample_valid <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (load) sample_out <= sat;
         sample_valid <= load || (sample_valid && !sample_ready);
         overrun <= set_ovr || (overrun && !clear_overrun);
      end
   end
endmodule
